// File: rtl/replenish_stock.sv
// ---------------------------------------------------------------------------
// replenish_stock
//   Per-slot stock keeper for a vending machine. Restocks are taken on a
//   rising edge of the debounced confirm level, validated, added with
//   saturation at MAX_STOCK and reported with done. Sales decrement a slot
//   directly in any FSM state and never underflow.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : machine enable, gates new restocks and all sales
//   re        : replenish mode select (1 = restock, 0 = sell)
//   re_count  : restock quantity 0..7 (0 = no selection)
//   item_sel  : one-hot restock slot
//   confirm   : debounced restock confirm level
//   sell      : one-cycle sale pulse
//   sell_sel  : one-hot slot being sold
//   stock     : packed 4-bit counts, slot i at [4i+3:4i]
//   busy      : restock in progress
//   done      : one-cycle pulse, restock committed
//   err       : one-cycle pulse, restock rejected
//   sat       : sticky, last accepted restock was clipped
//   sell_ok   : one-cycle pulse, sale accepted
//   sold_out  : per-slot flag, stock is 0
// ---------------------------------------------------------------------------
module replenish_stock #(
    parameter int ITEMS     = 4,
    parameter int MAX_STOCK = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 re,
    input  logic [2:0]           re_count,
    input  logic [ITEMS-1:0]     item_sel,
    input  logic                 confirm,
    input  logic                 sell,
    input  logic [ITEMS-1:0]     sell_sel,
    output logic [4*ITEMS-1:0]   stock,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 sat,
    output logic                 sell_ok,
    output logic [ITEMS-1:0]     sold_out
);

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

    state_t         state, state_nxt;
    logic           conf_q;
    logic           armed;
    logic [2:0]     cnt_q;
    logic [ITEMS-1:0] sel_q;
    logic [3:0]     level     [ITEMS];
    logic [3:0]     level_nxt [ITEMS];
    logic           conf_edge;
    logic           start;
    logic           sel_valid;
    logic           sell_onehot;
    logic           sale_nonzero;
    logic           sale_go;
    logic [3:0]     upd_base;
    logic [4:0]     sum;
    logic           clip;
    logic [3:0]     upd_val;

    // armed stays low after reset until confirm has been seen low, so a
    // level that was already high when reset released is not an edge.
    assign conf_edge = confirm & ~conf_q & armed;
    assign start     = conf_edge & en & re;

    // Confirm edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            conf_q <= confirm;
            if (!confirm)
                armed <= 1'b1;
        end
    end

    // Holding registers: only loaded when a restock is accepted from IDLE,
    // so a later drop of en or change of inputs cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else if (state == IDLE && start) begin
            cnt_q <= re_count;
            sel_q <= item_sel;
        end
    end

    // Validity of the captured restock and of the current sale request.
    always_comb begin
        sel_valid    = (cnt_q != 3'd0) && (sel_q != '0) &&
                       ((sel_q & (sel_q - ITEMS'(1))) == '0);
        sell_onehot  = (sell_sel != '0) &&
                       ((sell_sel & (sell_sel - ITEMS'(1))) == '0);
        sale_nonzero = 1'b0;
        upd_base     = 4'd0;
        for (int i = 0; i < ITEMS; i++) begin
            if (sell_sel[i] && level[i] != 4'd0)
                sale_nonzero = 1'b1;
            if (sel_q[i])
                upd_base = level[i];
        end
        sale_go = en & ~re & sell & sell_onehot & sale_nonzero;
        sum     = {1'b0, upd_base} + {2'b00, cnt_q};
        clip    = sum > 5'(MAX_STOCK);
        upd_val = clip ? 4'(MAX_STOCK) : sum[3:0];
    end

    // Next stock per slot: restock result first, then a same-cycle sale
    // on that slot is taken off the restocked value.
    always_comb begin
        level_nxt = level;
        for (int i = 0; i < ITEMS; i++) begin
            if (state == UPDATE && sel_q[i])
                level_nxt[i] = upd_val;
            if (sale_go && sell_sel[i])
                level_nxt[i] = level_nxt[i] - 4'd1;
        end
    end

    // Stock, saturation flag and sale acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ITEMS; i++)
                level[i] <= 4'd0;
            sat     <= 1'b0;
            sell_ok <= 1'b0;
        end else begin
            level   <= level_nxt;
            sell_ok <= sale_go;
            if (state == UPDATE)
                sat <= clip;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; err is raised for the single CHECK cycle that
    // rejects the captured request.
    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = CHECK;
            CHECK: begin
                if (sel_valid) begin
                    state_nxt = UPDATE;
                end else begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            UPDATE: state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Output packing and sold-out flags.
    always_comb begin
        stock    = '0;
        sold_out = '0;
        for (int i = 0; i < ITEMS; i++) begin
            stock[4*i +: 4] = level[i];
            sold_out[i]     = (level[i] == 4'd0);
        end
    end

endmodule
